sum_sq_feeder: RTL and testbench

//  Sequential sum-of-squares stage; sits directly upstream of the combinational integer square-root unit.

---
 rtl/sum_sq_feeder.sv | 101 ++++++++++
 tb/tb_sum_sq_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_sq_feeder.sv
// Sequential sum-of-squares stage: s = a*a + b*b via a bit-serial shift-add squarer,
// saturated to OUT_W bits, with valid/ready handshakes on both sides.
module sum_sq_feeder #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 21
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] a,
  input  logic signed [IN_W-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       s,
  output logic                   sat
);

  localparam int ACC_W = 2*IN_W + 1;
  localparam int CNT_W = $clog2(IN_W);

  typedef enum logic [1:0] {IDLE, SQ_A, SQ_B, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IN_W-1:0]   r_mag_a;
  logic [IN_W-1:0]   r_mag_b;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [OUT_W-1:0]  r_s;
  logic              r_sat;

  logic              w_accept;
  logic              w_last_bit;
  logic              w_busy;
  logic [IN_W-1:0]   w_mag_cur;
  logic [ACC_W-1:0]  w_addend;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = SQ_A;
      end
      SQ_A: if (w_last_bit) w_state_nxt = SQ_B;
      SQ_B: if (w_last_bit) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept   = in_valid && in_ready;
  assign w_last_bit = (r_cnt == CNT_W'(IN_W-1));
  assign w_busy     = (r_state == SQ_A) || (r_state == SQ_B);
  assign w_mag_cur  = (r_state == SQ_B) ? r_mag_b : r_mag_a;
  assign w_addend   = w_mag_cur[r_cnt] ? (ACC_W'(w_mag_cur) << r_cnt) : '0;
  assign w_acc_nxt  = r_acc + w_addend;
  // Any set bit at or above OUT_W means the sum exceeds the largest radicand.
  assign w_over     = |w_acc_nxt[ACC_W-1:OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      // Negating the most negative value wraps to 2^(IN_W-1), the correct unsigned magnitude.
      r_mag_a <= a[IN_W-1] ? $unsigned(-a) : $unsigned(a);
      r_mag_b <= b[IN_W-1] ? $unsigned(-b) : $unsigned(b);
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_busy) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_last_bit ? '0 : r_cnt + 1'b1;
      if ((r_state == SQ_B) && w_last_bit) begin
        r_s   <= w_over ? '1 : w_acc_nxt[OUT_W-1:0];
        r_sat <= w_over;
      end
    end
  end

  assign s   = r_s;
  assign sat = r_sat;

endmodule

// File: tb/tb_sum_sq_feeder.sv
// Self-checking bench for sum_sq_feeder: directed vector table, hand-written
// handshake/reset sequences, and randomized jobs against an arithmetic model.
module tb_sum_sq_feeder;

  localparam int IN_W  = 11;
  localparam int OUT_W = 21;
  localparam int S_MAX = (1 << OUT_W) - 1;
  localparam int LAT   = 2*IN_W;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] a;
  logic signed [IN_W-1:0] b;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       s;
  logic                   sat;

  int n_checks = 0;
  int n_errors = 0;

  sum_sq_feeder #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int exp_s;
    int exp_sat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_s(input int x, input int y);
    longint t;
    t = longint'(x)*x + longint'(y)*y;
    return (t > S_MAX) ? S_MAX : int'(t);
  endfunction

  function automatic int model_sat(input int x, input int y);
    longint t;
    t = longint'(x)*x + longint'(y)*y;
    return (t > S_MAX) ? 1 : 0;
  endfunction

  // Called at the negedge right after an accept edge; counts edges until out_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_job(input int ta, input int tb, input int es, input int esat,
                         input int stall, input string nm);
    int lat;
    @(negedge clk);
    a = IN_W'(ta);
    b = IN_W'(tb);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    chk({nm, " in_ready idle"}, int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = IN_W'($urandom);
    b = IN_W'($urandom);
    chk({nm, " in_ready busy"}, int'(in_ready), 0);
    wait_valid(lat);
    chk({nm, " latency"}, lat, LAT);
    chk({nm, " s"}, int'(s), es);
    chk({nm, " sat"}, int'(sat), esat);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, " held valid"}, int'(out_valid), 1);
      chk({nm, " held s"}, int'(s), es);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " consumed"}, int'(out_valid), 0);
    chk({nm, " ready again"}, int'(in_ready), 1);
  endtask

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int ra, rb;

    vecs[0] = '{3, -4, 25, 0};
    vecs[1] = '{-1024, -1024, 2097151, 1};
    vecs[2] = '{1023, -1024, 2095105, 0};
    vecs[3] = '{-1024, 0, 1048576, 0};
    vecs[4] = '{0, 0, 0, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset s", int'(s), 0);
    chk("reset sat", int'(sat), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_job(vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_sat, 0, $sformatf("vec%0d", i));

    // Backpressure: result held for 10 cycles while new requests are ignored.
    @(negedge clk);
    a = 11'sd5; b = 11'sd12; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp latency", lat, LAT);
    chk("bp s", int'(s), 169);
    for (int i = 0; i < 10; i++) begin
      a = 11'sd7; b = 11'sd0; in_valid = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      chk("bp s stable", int'(s), 169);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp consumed", int'(out_valid), 0);
    chk("bp idle", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp single result", int'(out_valid), 0);

    // Reset during SQ_B, after a saturated result left s/sat nonzero.
    run_job(-1024, -1024, S_MAX, 1, 0, "presat");
    @(negedge clk);
    a = 11'sd100; b = 11'sd100; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    chk("mid in_ready busy", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async s", int'(s), 0);
    chk("async sat", int'(sat), 0);
    chk("async in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(6, 8, 100, 0, 0, "post reset");

    // Back-to-back with in_valid held high.
    @(negedge clk);
    a = 11'sd3; b = 11'sd4; in_valid = 1'b1; out_ready = 1'b1;
    chk("b2b first ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    a = 11'sd8; b = 11'sd15;
    wait_valid(lat);
    chk("b2b first latency", lat, LAT);
    chk("b2b first s", int'(s), 25);
    @(posedge clk);
    @(negedge clk);
    chk("b2b handoff out_valid", int'(out_valid), 0);
    chk("b2b handoff in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b second accepted", int'(in_ready), 0);
    wait_valid(lat);
    chk("b2b second latency", lat, LAT);
    chk("b2b second s", int'(s), 289);
    chk("b2b second sat", int'(sat), 0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b drained", int'(out_valid), 0);

    for (int i = 0; i < 30; i++) begin
      ra = int'($urandom_range(0, 2047)) - 1024;
      rb = int'($urandom_range(0, 2047)) - 1024;
      if (i == 0) begin ra = -1024; rb = -1; end
      run_job(ra, rb, model_s(ra, rb), model_sat(ra, rb), int'($urandom_range(0, 3)),
              $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
